// File: rtl/mahjamma_pkg.sv
// Shared key indices, sequencer state encoding and output polarity helper for the mahjong key sequencer.
// Used by mahjamma_debounce and mahjamma_key_sequencer (optional debounce: MAHJAMMA_KEY_DEBOUNCE_EN).
package mahjamma_pkg;

  localparam int NUM_KEYS  = 20;
  localparam int KEY_START = 19;
  localparam int KEY_A     = 18;
  localparam int KEY_I     = 10;
  localparam int KEY_J     = 9;
  localparam int KEY_N     = 5;
  localparam int KEY_CHI   = 4;
  localparam int KEY_RON   = 0;
  localparam int BANK_HI   = 1;
  localparam int BANK_LO   = 0;

  typedef enum logic [2:0] {
    ST_SETUP_HI,
    ST_STROBE_HI,
    ST_HOLD_HI,
    ST_SETUP_LO,
    ST_STROBE_LO,
    ST_HOLD_LO
  } seq_state_e;

  function automatic logic key_encode(input logic pressed, input logic polarity);
    return pressed ? polarity : ~polarity;
  endfunction

endpackage

// File: rtl/mahjamma_debounce.sv
// One key input: 2-flop synchroniser followed by a stable-level debouncer.
// The debounce counter exists only when MAHJAMMA_KEY_DEBOUNCE_EN is defined; otherwise the synchroniser output is used.
module mahjamma_debounce
`ifdef MAHJAMMA_KEY_DEBOUNCE_EN
  #(
    parameter int DEBOUNCE_W      = 16,
    parameter int DEBOUNCE_CYCLES = 50000
  )
`endif
  (
  input  logic i_clk,
  input  logic i_resetX,
  input  logic i_raw,
  output logic o_stable
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk or negedge i_resetX) begin
    if (!i_resetX) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MAHJAMMA_KEY_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] r_count;
  logic                  r_stable;

  // Any return to the accepted level restarts the count, so only an unbroken run is accepted.
  always_ff @(posedge i_clk or negedge i_resetX) begin
    if (!i_resetX) begin
      r_count  <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_count <= '0;
    end else if (r_count == DEBOUNCE_W'(DEBOUNCE_CYCLES - 1)) begin
      r_stable <= r_sync2;
      r_count  <= '0;
    end else begin
      r_count <= r_count + DEBOUNCE_W'(1);
    end
  end

  assign o_stable = r_stable;
`else
  assign o_stable = r_sync2;
`endif

endmodule

// File: rtl/mahjamma_key_sequencer.sv
// Debounces 20 panel buttons, drives START..I directly and time-multiplexes the two 5-key banks with latch strobes.
// Debouncing is enabled by MAHJAMMA_KEY_DEBOUNCE_EN; without it each key sees only the 2-flop synchroniser.
module mahjamma_key_sequencer
  import mahjamma_pkg::*;
#(
  parameter int DEBOUNCE_W      = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SETUP_CYCLES    = 4,
  parameter int STROBE_CYCLES   = 4,
  parameter int HOLD_CYCLES     = 4
) (
  input  logic                i_clk,
  input  logic                i_resetX,
  input  logic [NUM_KEYS-1:0] i_keyRaw,
  input  logic                i_polarity,
  output logic [14:0]         o_key,
  output logic [1:0]          o_keyClk,
  output logic [1:0]          o_bankValid
);

  localparam int MAX_A    = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_CYC  = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int PHASE_W  = $clog2(MAX_CYC + 1);

  logic [NUM_KEYS-1:0] w_stable;
  logic [NUM_KEYS-1:0] w_enc;

  seq_state_e          r_state;
  seq_state_e          w_nextState;
  logic [PHASE_W-1:0]  r_phase;
  logic [PHASE_W-1:0]  w_nextPhase;
  logic [PHASE_W-1:0]  w_limit;
  logic                w_lastPhase;
  logic                w_enterSetup;
  logic                w_polChange;
  logic [1:0]          w_nextClk;

  logic [14:0]         r_key;
  logic [1:0]          r_keyClk;
  logic [1:0]          r_bankValid;
  logic                r_polarity;
  logic                r_polArmed;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    mahjamma_debounce
`ifdef MAHJAMMA_KEY_DEBOUNCE_EN
      #(
        .DEBOUNCE_W      (DEBOUNCE_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      )
`endif
      u_debounce (
        .i_clk    (i_clk),
        .i_resetX (i_resetX),
        .i_raw    (i_keyRaw[g]),
        .o_stable (w_stable[g])
      );
  end

  always_comb begin
    w_enc = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_enc[k] = key_encode(w_stable[k], i_polarity);
    end
  end

  // The armed flag stops the first post-reset cycle from seeing a bogus polarity change.
  assign w_polChange = r_polArmed && (i_polarity != r_polarity);

  always_comb begin
    w_limit = PHASE_W'(SETUP_CYCLES - 1);
    case (r_state)
      ST_STROBE_HI, ST_STROBE_LO: w_limit = PHASE_W'(STROBE_CYCLES - 1);
      ST_HOLD_HI,   ST_HOLD_LO:   w_limit = PHASE_W'(HOLD_CYCLES - 1);
      default:                    w_limit = PHASE_W'(SETUP_CYCLES - 1);
    endcase
    w_lastPhase = (r_phase == w_limit);

    w_nextState  = r_state;
    w_nextPhase  = r_phase + PHASE_W'(1);
    w_enterSetup = 1'b0;
    if (w_polChange) begin
      w_nextState  = ST_SETUP_HI;
      w_nextPhase  = '0;
      w_enterSetup = 1'b1;
    end else if (w_lastPhase) begin
      w_nextPhase = '0;
      case (r_state)
        ST_SETUP_HI:  w_nextState = ST_STROBE_HI;
        ST_STROBE_HI: w_nextState = ST_HOLD_HI;
        ST_HOLD_HI:   w_nextState = ST_SETUP_LO;
        ST_SETUP_LO:  w_nextState = ST_STROBE_LO;
        ST_STROBE_LO: w_nextState = ST_HOLD_LO;
        default:      w_nextState = ST_SETUP_HI;
      endcase
      w_enterSetup = (r_state == ST_HOLD_HI) || (r_state == ST_HOLD_LO);
    end

    w_nextClk          = 2'b00;
    w_nextClk[BANK_HI] = (w_nextState == ST_STROBE_HI);
    w_nextClk[BANK_LO] = (w_nextState == ST_STROBE_LO);
  end

  always_ff @(posedge i_clk or negedge i_resetX) begin
    if (!i_resetX) begin
      r_state    <= ST_SETUP_HI;
      r_phase    <= '0;
      r_polarity <= 1'b0;
      r_polArmed <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_phase    <= w_nextPhase;
      r_polarity <= i_polarity;
      r_polArmed <= 1'b1;
    end
  end

  // Strobes come from the next state so they are registered and line up with the state they belong to.
  always_ff @(posedge i_clk or negedge i_resetX) begin
    if (!i_resetX) begin
      r_key       <= 15'h7FFF;
      r_keyClk    <= 2'b00;
      r_bankValid <= 2'b00;
    end else begin
      r_key[14:5] <= w_enc[KEY_START:KEY_I];
      if (w_enterSetup) begin
        r_key[4:0] <= (w_nextState == ST_SETUP_HI) ? w_enc[KEY_J:KEY_N] : w_enc[KEY_CHI:KEY_RON];
      end
      r_keyClk    <= w_nextClk;
      r_bankValid <= r_bankValid | w_nextClk;
    end
  end

  assign o_key       = r_key;
  assign o_keyClk    = r_keyClk;
  assign o_bankValid = r_bankValid;

endmodule

// File: tb/tb_mahjamma_key_sequencer.sv
// Directed testbench for mahjamma_key_sequencer with 4/4/4 phase timing and an 8-cycle debounce.
// Expected latencies follow MAHJAMMA_KEY_DEBOUNCE_EN so the bench suits both builds.
module tb_mahjamma_key_sequencer;
  import mahjamma_pkg::*;

  localparam int DB_CYCLES = 8;
`ifdef MAHJAMMA_KEY_DEBOUNCE_EN
  localparam int LAT = DB_CYCLES + 3;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        resetX;
  logic [19:0] keyRaw;
  logic        polarity;
  logic [14:0] key;
  logic [1:0]  keyClk;
  logic [1:0]  bankValid;

  int total;
  int bad;

  mahjamma_key_sequencer #(
    .DEBOUNCE_W      (16),
    .DEBOUNCE_CYCLES (DB_CYCLES),
    .SETUP_CYCLES    (4),
    .STROBE_CYCLES   (4),
    .HOLD_CYCLES     (4)
  ) dut (
    .i_clk       (clk),
    .i_resetX    (resetX),
    .i_keyRaw    (keyRaw),
    .i_polarity  (polarity),
    .o_key       (key),
    .o_keyClk    (keyClk),
    .o_bankValid (bankValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [19:0] raw, input logic pol);
    keyRaw   = raw;
    polarity = pol;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitForClk(input logic [1:0] pat, input string tag);
    int n;
    n = 0;
    while (keyClk !== pat && n < 64) begin
      step(1);
      n++;
    end
    checkOutput(tag, {30'd0, keyClk}, {30'd0, pat});
  endtask

  logic [19:0] chi;
  logic [19:0] keyA;
  logic [19:0] keyN;
  logic        seen;

  initial begin
    total = 0;
    bad   = 0;
    chi   = 20'd1 << KEY_CHI;
    keyA  = 20'd1 << KEY_A;
    keyN  = 20'd1 << KEY_N;
    resetX = 1'b0;
    applyStimulus(20'd0, 1'b0);
    step(2);
    $display("[TB] reset and idle sequencing");
    checkOutput("rst_key", {17'd0, key}, 32'h7FFF);
    checkOutput("rst_clk", {30'd0, keyClk}, 32'h0);
    checkOutput("rst_valid", {30'd0, bankValid}, 32'h0);
    resetX = 1'b1;
    checkOutput("c0_clk", {30'd0, keyClk}, 32'h0);
    step(3);
    checkOutput("c3_clk", {30'd0, keyClk}, 32'h0);
    step(1);
    checkOutput("c4_clk", {30'd0, keyClk}, 32'h2);
    checkOutput("c4_valid", {30'd0, bankValid}, 32'h2);
    step(3);
    checkOutput("c7_clk", {30'd0, keyClk}, 32'h2);
    step(1);
    checkOutput("c8_clk", {30'd0, keyClk}, 32'h0);
    step(8);
    checkOutput("c16_clk", {30'd0, keyClk}, 32'h1);
    checkOutput("c16_valid", {30'd0, bankValid}, 32'h3);
    checkOutput("c16_key", {17'd0, key}, 32'h7FFF);
    step(3);
    checkOutput("c19_clk", {30'd0, keyClk}, 32'h1);
    step(1);
    checkOutput("c20_clk", {30'd0, keyClk}, 32'h0);

    $display("[TB] CHI pressed with active-high polarity");
    applyStimulus(chi, 1'b1);
    step(1);
    checkOutput("pol_abort_key", {17'd0, key}, 32'h0000);
    checkOutput("pol_abort_clk", {30'd0, keyClk}, 32'h0);
    step(4);
    checkOutput("restart_strobe_hi", {30'd0, keyClk}, 32'h2);
    step(8);
    checkOutput("chi_setup_lo_key", {17'd0, key}, 32'h0010);
    step(4);
    checkOutput("chi_strobe_clk", {30'd0, keyClk}, 32'h1);
    checkOutput("chi_strobe_key", {17'd0, key}, 32'h0010);
    step(3);
    checkOutput("chi_strobe_end_key", {17'd0, key}, 32'h0010);
    step(1);
    checkOutput("chi_hold_clk", {30'd0, keyClk}, 32'h0);

    $display("[TB] glitch and press on A");
`ifdef MAHJAMMA_KEY_DEBOUNCE_EN
    for (int p = 0; p < 2; p++) begin
      seen = 1'b0;
      applyStimulus(chi | keyA, 1'b1);
      for (int i = 0; i < ((p == 0) ? 5 : DB_CYCLES - 1); i++) begin
        step(1);
        seen |= key[13];
      end
      applyStimulus(chi, 1'b1);
      for (int i = 0; i < DB_CYCLES + 6; i++) begin
        step(1);
        seen |= key[13];
      end
      checkOutput((p == 0) ? "glitch5_A" : "glitch7_A", {31'd0, seen}, 32'h0);
    end
`else
    applyStimulus(chi | keyA, 1'b1);
    step(3);
    checkOutput("pulse_A_on", {31'd0, key[13]}, 32'h1);
    step(2);
    applyStimulus(chi, 1'b1);
    step(3);
    checkOutput("pulse_A_off", {31'd0, key[13]}, 32'h0);
`endif
    applyStimulus(chi | keyA, 1'b1);
    step(LAT - 1);
    checkOutput("press_A_before", {31'd0, key[13]}, 32'h0);
    step(1);
    checkOutput("press_A_edge", {31'd0, key[13]}, 32'h1);
    step(20 - LAT);
    applyStimulus(chi, 1'b1);
    step(LAT - 1);
    checkOutput("release_A_before", {31'd0, key[13]}, 32'h1);
    step(1);
    checkOutput("release_A_edge", {31'd0, key[13]}, 32'h0);

    $display("[TB] polarity toggle during bank HI strobe");
    waitForClk(2'b00, "wait_idle");
    waitForClk(2'b10, "wait_strobe_hi");
    step(1);
    applyStimulus(chi, 1'b0);
    step(1);
    checkOutput("toggle_clk", {30'd0, keyClk}, 32'h0);
    checkOutput("toggle_key", {17'd0, key}, 32'h7FFF);
    checkOutput("toggle_valid", {30'd0, bankValid}, 32'h3);
    step(3);
    checkOutput("toggle_setup_clk", {30'd0, keyClk}, 32'h0);
    step(1);
    checkOutput("toggle_restart_clk", {30'd0, keyClk}, 32'h2);

    $display("[TB] reset during bank LO strobe");
    waitForClk(2'b01, "wait_strobe_lo");
    checkOutput("strobe_lo_key", {17'd0, key}, 32'h7FEF);
    step(1);
    #2;
    resetX = 1'b0;
    #1;
    checkOutput("async_rst_clk", {30'd0, keyClk}, 32'h0);
    checkOutput("async_rst_key", {17'd0, key}, 32'h7FFF);
    checkOutput("async_rst_valid", {30'd0, bankValid}, 32'h0);

    $display("[TB] N pressed across reset release");
    step(2);
    applyStimulus(chi | keyN, 1'b0);
    resetX = 1'b1;
    step(12);
    checkOutput("n_setup_lo_key", {17'd0, key}, 32'h7FEF);
    step(12);
    checkOutput("n_setup_hi_key", {17'd0, key}, 32'h7FFE);
    step(4);
    checkOutput("n_strobe_hi_clk", {30'd0, keyClk}, 32'h2);
    checkOutput("n_strobe_hi_key", {17'd0, key}, 32'h7FFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
